// File: rtl/adder_sum_accumulator_if.sv
// ---------------------------------------------------------------------------
// adder_sum_accumulator_if
//   Groups the sample, control and result signals of adder_sum_accumulator.
//   clk and rst_n stay plain ports on the module.
//
//   Signals:
//     start      run request, honoured only while the accumulator is idle
//     in_valid   sum_in/carry_in hold a valid adder result
//     sum_in     adder sum z[1:0]
//     carry_in   adder carry
//     in_ready   accumulator accepts a sample this cycle
//     acc        running or final total (ACC_W bits)
//     count      samples accepted in the current run (CNT_W bits)
//     overflow   sticky: the total wrapped during the run
//     out_valid  final total available
//     out_ready  consumer takes the total
//
//   Modports:
//     master  producer/consumer side (drives samples, start, out_ready)
//     slave   accumulator side
// ---------------------------------------------------------------------------
interface adder_sum_accumulator_if #(
  parameter int ACC_W = 8,
  parameter int CNT_W = 3
);
  logic             start;
  logic             in_valid;
  logic [1:0]       sum_in;
  logic             carry_in;
  logic             in_ready;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output start, in_valid, sum_in, carry_in, out_ready,
    input  in_ready, acc, count, overflow, out_valid
  );

  modport slave (
    input  start, in_valid, sum_in, carry_in, out_ready,
    output in_ready, acc, count, overflow, out_valid
  );
endinterface

// File: rtl/adder_sum_accumulator.sv
// ---------------------------------------------------------------------------
// adder_sum_accumulator
//   Sums NUM_SAMPLES results of the two-bit adder stage ({carry, z}, 0..7)
//   into an ACC_W-bit running total, then offers the total to a consumer
//   with a valid/ready handshake. A single-cycle start opens each run.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    adder_sum_accumulator_if.slave (see interface header)
//
//   Parameters:
//     ACC_W        accumulator width, minimum 3 (one sample must fit)
//     NUM_SAMPLES  samples per run, 1 .. 2**CNT_W-1
//     CNT_W        sample counter width
//
//   The bus interface instance must use the same ACC_W and CNT_W.
// ---------------------------------------------------------------------------
module adder_sum_accumulator #(
  parameter int ACC_W       = 8,
  parameter int NUM_SAMPLES = 7,
  parameter int CNT_W       = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  adder_sum_accumulator_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ACCUM = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  state_t state, state_nxt;

  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;

  logic             is_accum;
  logic             accept;
  logic             last;
  logic [ACC_W-1:0] sample;
  logic [ACC_W:0]   sum_ext;

  assign is_accum = (state == S_ACCUM);
  assign accept   = bus.in_valid & is_accum;
  // The accept taking count from NUM_SAMPLES-1 completes the run.
  assign last     = (count_q == CNT_W'(NUM_SAMPLES - 1));
  assign sample   = ACC_W'({bus.carry_in, bus.sum_in});
  // One extra bit captures the carry-out that feeds the sticky overflow.
  assign sum_ext  = {1'b0, acc_q} + {1'b0, sample};

  // State register
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start)      state_nxt = S_ACCUM;
      S_ACCUM: if (accept && last) state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready)  state_nxt = S_IDLE;
      default:                     state_nxt = S_IDLE;  // illegal 2'b11
    endcase
  end

  // Handshake outputs decode from state only, so reset drops them at once.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      S_ACCUM: bus.in_ready  = 1'b1;
      S_DONE:  bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: cleared by start in IDLE, updated on accept, otherwise held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (state == S_IDLE && bus.start) begin
      acc_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (accept) begin
      acc_q      <= sum_ext[ACC_W-1:0];
      count_q    <= count_q + CNT_W'(1);
      overflow_q <= overflow_q | sum_ext[ACC_W];
    end
  end

  assign bus.acc      = acc_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// ---------------------------------------------------------------------------
// tb_adder_sum_accumulator
//   Directed bench for adder_sum_accumulator. Three instances share the
//   sample/out_ready stimulus and have separate start lines; only the one
//   that was started is in ACCUM, so the others ignore the shared samples.
//     u_a  ACC_W=8 NUM_SAMPLES=7  basic, gaps/backpressure, ignored start,
//                                 mid-run reset
//     u_b  ACC_W=4 NUM_SAMPLES=7  wrap-around and sticky overflow
//     u_c  ACC_W=8 NUM_SAMPLES=1  single-sample run
//   Inputs change and outputs are checked on the falling edge.
// ---------------------------------------------------------------------------
module tb_adder_sum_accumulator;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start_a, start_b, start_c;
  logic       in_valid;
  logic [1:0] sum_in;
  logic       carry_in;
  logic       out_ready;

  int errors = 0;
  int checks = 0;

  adder_sum_accumulator_if #(.ACC_W(8), .CNT_W(3)) a_if ();
  adder_sum_accumulator_if #(.ACC_W(4), .CNT_W(3)) b_if ();
  adder_sum_accumulator_if #(.ACC_W(8), .CNT_W(3)) c_if ();

  assign a_if.start = start_a;
  assign b_if.start = start_b;
  assign c_if.start = start_c;

  assign a_if.in_valid = in_valid;  assign a_if.sum_in = sum_in;
  assign a_if.carry_in = carry_in;  assign a_if.out_ready = out_ready;
  assign b_if.in_valid = in_valid;  assign b_if.sum_in = sum_in;
  assign b_if.carry_in = carry_in;  assign b_if.out_ready = out_ready;
  assign c_if.in_valid = in_valid;  assign c_if.sum_in = sum_in;
  assign c_if.carry_in = carry_in;  assign c_if.out_ready = out_ready;

  adder_sum_accumulator #(.ACC_W(8), .NUM_SAMPLES(7), .CNT_W(3)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  adder_sum_accumulator #(.ACC_W(4), .NUM_SAMPLES(7), .CNT_W(3)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if.slave));
  adder_sum_accumulator #(.ACC_W(8), .NUM_SAMPLES(1), .CNT_W(3)) u_c (
    .clk(clk), .rst_n(rst_n), .bus(c_if.slave));

  // Adder results of the operand pairs (0,1),(1,1),(2,0),(2,1),(3,1),(3,2),(3,3)
  int unsigned basic_vals [7] = '{1, 2, 2, 3, 4, 5, 6};  // total 23

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; presents one sample for one rising edge.
  task automatic send(input int unsigned v);
    logic [2:0] s;
    s        = 3'(v);
    in_valid = 1'b1;
    carry_in = s[2];
    sum_in   = s[1:0];
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    in_valid = 1'b0; sum_in = 2'b00; carry_in = 1'b0; out_ready = 1'b0;

    // ---------------- reset state
    #3;
    check("rst_a_acc",      a_if.acc,       0);
    check("rst_a_count",    a_if.count,     0);
    check("rst_a_overflow", a_if.overflow,  0);
    check("rst_a_in_ready", a_if.in_ready,  0);
    check("rst_a_out_valid",a_if.out_valid, 0);
    check("rst_b_in_ready", b_if.in_ready,  0);
    check("rst_c_out_valid",c_if.out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_a_in_ready", a_if.in_ready, 0);

    // ---------------- basic run, continuous samples
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    check("basic_in_ready", a_if.in_ready, 1);
    check("basic_count0",   a_if.count,    0);
    send(basic_vals[0]);
    check("basic_acc1",     a_if.acc,      1);
    check("basic_count1",   a_if.count,    1);
    for (int i = 1; i < 6; i++) send(basic_vals[i]);
    check("basic_ov6_low",  a_if.out_valid, 0);
    send(basic_vals[6]);
    check("basic_out_valid",a_if.out_valid, 1);
    check("basic_acc",      a_if.acc,       23);
    check("basic_count",    a_if.count,     7);
    check("basic_overflow", a_if.overflow,  0);
    check("basic_done_in_ready", a_if.in_ready, 0);
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    check("basic_ov_fall",  a_if.out_valid, 0);
    check("basic_acc_hold", a_if.acc,       23);

    // ---------------- gaps and 3 cycles of backpressure
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    check("gap_cleared",    a_if.acc,       0);
    send(basic_vals[0]);
    idle_cycle();
    check("gap_count_hold", a_if.count,     1);
    check("gap_acc_hold",   a_if.acc,       1);
    for (int i = 1; i < 7; i++) begin
      send(basic_vals[i]);
      if (i < 6) idle_cycle();
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("gap_done_valid%0d", k), a_if.out_valid, 1);
      check($sformatf("gap_done_ready%0d", k), a_if.in_ready,  0);
      if (k == 3) out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("gap_ov_fall",    a_if.out_valid, 0);
    check("gap_acc",        a_if.acc,       23);

    // ---------------- start ignored during ACCUM and DONE
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    for (int i = 0; i < 3; i++) send(basic_vals[i]);
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    check("ign_accum_acc",   a_if.acc,   5);
    check("ign_accum_count", a_if.count, 3);
    for (int i = 3; i < 7; i++) send(basic_vals[i]);
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    check("ign_done_valid",  a_if.out_valid, 1);
    check("ign_done_acc",    a_if.acc,       23);
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    check("ign_idle_acc",    a_if.acc,       23);
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    check("ign_restart_acc",   a_if.acc,      0);
    check("ign_restart_count", a_if.count,    0);

    // ---------------- asynchronous reset mid-run
    for (int i = 0; i < 4; i++) send(basic_vals[i]);
    check("mid_acc_before", a_if.acc, 8);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_acc",       a_if.acc,       0);
    check("mid_rst_count",     a_if.count,     0);
    check("mid_rst_in_ready",  a_if.in_ready,  0);
    check("mid_rst_out_valid", a_if.out_valid, 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_idle_in_ready", a_if.in_ready, 0);
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    for (int i = 0; i < 7; i++) send(basic_vals[i]);
    check("mid_fresh_acc",   a_if.acc,       23);
    check("mid_fresh_count", a_if.count,     7);
    check("mid_fresh_valid", a_if.out_valid, 1);
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    check("mid_drain",       a_if.out_valid, 0);

    // ---------------- NUM_SAMPLES=1, out_ready held high in advance
    out_ready = 1'b1;
    start_c = 1'b1; @(negedge clk); start_c = 1'b0;
    check("one_in_ready", c_if.in_ready, 1);
    send(7);
    check("one_out_valid", c_if.out_valid, 1);
    check("one_acc",       c_if.acc,       7);
    check("one_count",     c_if.count,     1);
    @(negedge clk);
    check("one_ov_fall",   c_if.out_valid, 0);
    check("one_acc_hold",  c_if.acc,       7);
    out_ready = 1'b0;

    // ---------------- wrap-around and sticky overflow (ACC_W=4)
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    send(6); send(6);
    check("ovf_acc12",  b_if.acc,      12);
    check("ovf_flag12", b_if.overflow, 0);
    send(6);
    check("ovf_acc18",  b_if.acc,      2);
    check("ovf_flag18", b_if.overflow, 1);
    for (int i = 3; i < 7; i++) send(6);
    check("ovf_acc",    b_if.acc,       10);
    check("ovf_flag",   b_if.overflow,  1);
    check("ovf_valid",  b_if.out_valid, 1);
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    check("ovf_idle_flag", b_if.overflow, 1);
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    check("ovf_clear_flag", b_if.overflow, 0);
    check("ovf_clear_acc",  b_if.acc,      0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
